store_data_aligner: RTL and testbench
=====================================

// Module: store_data_aligner
// PURPOSE
//  Write-side counterpart of the load/immediate extend path. Narrows a 32-bit
//  register operand to byte/halfword/word store data, lane-aligns it with byte
//  enables, and drives a word-aligned data-memory write port.
//  Misaligned stores are split into two aligned word beats.
//  Sits between the EX-stage store request and the data-memory write port.
// PARAMETERS
//  ADDR_W  32  byte-address width; mem_addr wraps modulo 2^ADDR_W
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       store request valid
//  req_ready    out  1       block can accept request (=1 only in IDLE)
//  req_addr     in   ADDR_W  byte address
//  req_data     in   32      register operand; only low 8/16/32 bits used
//  req_size     in   2       00=byte 01=half 10=word 11=treated as word
//  mem_valid    out  1       write beat valid; held until mem_ready
//  mem_ready    in   1       memory accepts beat when mem_valid&&mem_ready
//  mem_addr     out  ADDR_W  word-aligned address (low 2 bits always 0)
//  mem_wdata    out  32      lane-aligned write data
//  mem_be       out  4       byte enables, bit k = byte lane k
//  done         out  1       1-cycle pulse after last beat accepted
//  misalign_err out  1       only with STORE_MISALIGN_TRAP_EN (see CONFIG)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0,
//    mem_be=0, done=0, misalign_err=0. Reset mid-transfer drops the pending
//    beat(s) immediately; no done pulse.
//  - Little-endian lanes: off=req_addr[1:0]; mask=1/3/F for byte/half/word.
//    wide_be[7:0]=mask<<off; wide_data[63:0]=sized_data<<(8*off), where
//    sized_data is req_data with unused high bytes zeroed.
//  - Beat0: addr={req_addr[ADDR_W-1:2],2'b00}, be=wide_be[3:0],
//    wdata=wide_data[31:0]. Beat1 (only if wide_be[7:4]!=0): addr=beat0+4
//    (wraps), be=wide_be[7:4], wdata=wide_data[63:32].
//  - FSM: IDLE -> BEAT0 on req_valid&&req_ready (cycle N); all request
//    fields and both beats captured at N. mem_valid=1 from N+1.
//    BEAT0 --mem_ready--> BEAT1 if split, else IDLE. BEAT1 --mem_ready--> IDLE.
//    done=1 in the cycle after the final handshake; req_ready=1 same cycle.
//  - Min latency: accept N, beat at N+1, done at N+2 (mem_ready tied high).
//  - mem_addr/wdata/be stable while mem_valid && !mem_ready. mem_be=0 and
//    mem_valid=0 whenever not in BEAT0/BEAT1.
//  - req_valid while busy is ignored (req_ready=0); requester holds.
//  - Byte stores never split; half splits only at off=3; word splits at off!=0.
// CONFIGURATION
//  STORE_MISALIGN_TRAP_EN defined: request with half&&off[0]!=0 or
//    word&&off!=0 issues no beat; misalign_err=1 and done=1 for one cycle at
//    N+1; next request accepted at N+1. Aligned requests unchanged.
//  Not defined: misaligned stores split as above; misalign_err tied 0.
// TESTING
//  1 byte: addr=0x1003, data=0xAABBCCDD -> one beat addr 0x1000, be=1000,
//    wdata=0xDD000000; done at N+2.
//  2 word split: addr=0x2002, data=0x11223344 -> beat0 0x2000 be=1100
//    wdata=0x33440000; beat1 0x2004 be=0011 wdata=0x00001122.
//  3 wrap: word at 0xFFFFFFFF -> beat0 0xFFFFFFFC be=1000, beat1 0x00000000
//    be=0111; trap build: misalign_err pulse, no mem_valid.
//  4 backpressure: half addr=0x10, mem_ready low 3 cycles -> mem_valid and
//    outputs stable 3 cycles, req_ready=0, single done after handshake.
//  5 reset mid-split: assert reset in BEAT1 -> next cycle mem_valid=0,
//    req_ready=1, done=0; following aligned word stores normally.
//  6 back-to-back: req_valid held with 3 aligned words, mem_ready=1 ->
//    accepts every 2 cycles, beats in order, 3 done pulses.

Source files
------------

// File: rtl/store_data_aligner.sv
// store_data_aligner: narrows a 32-bit store operand to byte, half or word size.
// It lane-aligns the data with byte enables and drives a word-aligned write port.
// A store that crosses a word boundary is issued as two aligned beats.
// Optional feature macro: STORE_MISALIGN_TRAP_EN. When it is defined, a
// misaligned half or word store issues no beat. Instead the block pulses
// misalign_err_o and done_o for one cycle.
module store_data_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_data_i,
    input  logic [1:0]        req_size_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output logic              done_o,
    output logic              misalign_err_o
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       hi_data_q, hi_data_d;
    logic [3:0]        hi_be_q, hi_be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [1:0]        off;
    logic [3:0]        mask;
    logic [31:0]       sized;
    logic [7:0]        wide_be;
    logic [63:0]       wide_data;
`ifdef STORE_MISALIGN_TRAP_EN
    logic              misalign;
`endif

    // Size the operand and spread it across an 8-lane (two word) window.
    always_comb begin
        off = req_addr_i[1:0];
        case (req_size_i)
            2'b00: begin
                mask  = 4'h1;
                sized = {24'd0, req_data_i[7:0]};
            end
            2'b01: begin
                mask  = 4'h3;
                sized = {16'd0, req_data_i[15:0]};
            end
            default: begin
                mask  = 4'hF;
                sized = req_data_i;
            end
        endcase
        wide_be   = {4'd0, mask} << off;
        wide_data = {32'd0, sized} << {off, 3'b000};
`ifdef STORE_MISALIGN_TRAP_EN
        misalign  = ((req_size_i == 2'b01) && off[0]) || (req_size_i[1] && (off != 2'b00));
`endif
    end

    // Next-state logic. Both beats are captured at accept, so the request can change freely after that.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        hi_data_d = hi_data_q;
        hi_be_d   = hi_be_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
`ifdef STORE_MISALIGN_TRAP_EN
                    if (misalign) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else
`endif
                    begin
                        state_d   = BEAT0;
                        addr_d    = {req_addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d   = wide_data[31:0];
                        be_d      = wide_be[3:0];
                        hi_data_d = wide_data[63:32];
                        hi_be_d   = wide_be[7:4];
                    end
                end
            end
            BEAT0: begin
                if (mem_ready_i) begin
                    if (hi_be_q != 4'd0) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + ADDR_W'(4);
                        wdata_d = hi_data_q;
                        be_d    = hi_be_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and beat registers. Reset drops any pending beat without signalling done.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            hi_data_q <= '0;
            hi_be_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            hi_data_q <= hi_data_d;
            hi_be_q   <= hi_be_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign mem_valid_o    = (state_q != IDLE);
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_be_o       = mem_valid_o ? be_q : 4'd0;
    assign done_o         = done_q;
    assign misalign_err_o = err_q;

endmodule

// File: tb/tb_store_data_aligner.sv
// tb_store_data_aligner: directed and randomized store traffic.
// Every output is compared each cycle against a byte-level reference model.
module tb_store_data_aligner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        misalign_err;

`ifdef STORE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    store_data_aligner #(.ADDR_W(32)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .done_o(done), .misalign_err_o(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_done = 0;
    bit    exp_err = 0;
    bit    after_rst = 1;
    bit    acc;
    int    cyc = 0;
    int    n_done_seen = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: walk the stored bytes one at a time and group them by word address.
    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int nbytes;
        logic [31:0] ba, wa;
        int lane;
        logic [7:0] byt;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) begin
            ba   = a + 32'(i);
            wa   = ba - (ba % 4);
            lane = int'(ba % 4);
            byt  = 8'((d >> (8 * i)) & 32'hFF);
            if (exp_q.size() == 0 || exp_q[exp_q.size()-1].addr != wa)
                exp_q.push_back('{addr: wa, be: 4'd0, data: 32'd0});
            exp_q[exp_q.size()-1].be   = exp_q[exp_q.size()-1].be | 4'(1 << lane);
            exp_q[exp_q.size()-1].data = exp_q[exp_q.size()-1].data | (32'(byt) << (8 * lane));
        end
    endtask

    // One clock: check outputs at negedge, drive the next inputs, then advance the model.
    task automatic step(input logic rv, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic mr, input logic rst);
        bit mis, nd, ne;
        @(negedge clk);
        cyc++;
        check("req_ready", req_ready, exp_q.size() == 0);
        check("mem_valid", mem_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("mem_addr", mem_addr, exp_q[0].addr);
            check("mem_be", mem_be, exp_q[0].be);
            check("mem_wdata", mem_wdata, exp_q[0].data);
        end else begin
            check("mem_be_idle", mem_be, 4'd0);
        end
        check("done", done, exp_done);
        check("misalign_err", misalign_err, exp_err);
        if (after_rst) begin
            check("rst_addr", mem_addr, 32'd0);
            check("rst_wdata", mem_wdata, 32'd0);
        end
        if (done === 1'b1) n_done_seen++;
        req_valid = rv; req_addr = a; req_data = d; req_size = sz;
        mem_ready = mr; reset = rst;
        nd = 0; ne = 0; acc = 0;
        if (rst) begin
            exp_q.delete();
            after_rst = 1;
        end else begin
            after_rst = 0;
            if (exp_q.size() != 0) begin
                if (mr) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) nd = 1;
                end
            end else if (rv) begin
                acc = 1;
                mis = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
                if (TRAP && mis) begin
                    nd = 1; ne = 1;
                end else begin
                    model_store(a, d, sz);
                end
            end
        end
        exp_done = nd; exp_err = ne;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    endtask

    logic [31:0] b2b_addr[3] = '{32'h100, 32'h204, 32'h308};
    logic [31:0] b2b_data[3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};

    initial begin
        int idx, last_acc, guard;
        repeat (2) @(posedge clk);
        // reset state and directed cases
        idle(1);
        step(1'b1, 32'h1003, 32'hAABBCCDD, 2'd0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 32'h2002, 32'h11223344, 2'd2, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 32'hFFFFFFFF, 32'h55667788, 2'd2, 1'b1, 1'b0);
        idle(4);
        // backpressure on a half store
        step(1'b1, 32'h10, 32'h0000BEEF, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 32'h1, 2'd2, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0);
        idle(3);
        // reset while the second beat is pending
        step(1'b1, 32'h2002, 32'h11223344, 2'd2, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'h3000, 32'h99887766, 2'd2, 1'b1, 1'b0);
        idle(3);
        // back-to-back aligned words with req_valid held
        n_done_seen = 0; idx = 0; last_acc = 0; guard = 0;
        while (idx < 3 && guard < 30) begin
            step(1'b1, b2b_addr[idx], b2b_data[idx], 2'd2, 1'b1, 1'b0);
            if (acc) begin
                if (idx > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                idx++;
            end
            guard++;
        end
        check("b2b_accepts", 32'(idx), 32'd3);
        idle(3);
        check("b2b_dones", 32'(n_done_seen), 32'd3);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            step(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
